// File: rtl/gauss_imgd_port_arb.sv
// Port arbiter for the single-port destination image RAM: reads always win,
// writes wait in a small FIFO and use idle cycles; queued writes forward to reads.
module gauss_imgd_port_arb #(
   parameter int DEPTH = 8,
   parameter int AW    = 10,
   parameter int DW    = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     rd_en,
   input  logic [AW-1:0]            rd_px,
   input  logic [AW-1:0]            rd_py,
   output logic [DW-1:0]            rd_dt,
   output logic                     rd_vl,
   input  logic                     wr_en,
   input  logic [AW-1:0]            wr_px,
   input  logic [AW-1:0]            wr_py,
   input  logic [DW-1:0]            wr_dt,
   output logic                     ram_en,
   output logic                     ram_we,
   output logic [AW-1:0]            ram_px,
   output logic [AW-1:0]            ram_py,
   output logic [DW-1:0]            ram_wdt,
   input  logic [DW-1:0]            ram_rd_dt,
   input  logic                     ram_rd_vl,
   output logic [$clog2(DEPTH):0]   fifo_cnt,
   output logic                     empty,
   output logic                     ovf
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] r_fifo_px [DEPTH];
   logic [AW-1:0] r_fifo_py [DEPTH];
   logic [DW-1:0] r_fifo_dt [DEPTH];

   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_cnt;
   logic          r_ovf;

   logic          r_ram_en;
   logic          r_ram_we;
   logic [AW-1:0] r_ram_px;
   logic [AW-1:0] r_ram_py;
   logic [DW-1:0] r_ram_wdt;

   logic          r_hit1;
   logic          r_hit2;
   logic [DW-1:0] r_fdt1;
   logic [DW-1:0] r_fdt2;

   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic          w_drop;
   logic [DEPTH-1:0] w_match;
   logic [DW-1:0] w_mdt [DEPTH];
   logic          w_fwd_hit;
   logic [DW-1:0] w_fwd_dt;

   assign w_full = (r_cnt == CW'(DEPTH));
   assign w_pop  = !rd_en && (r_cnt != '0);
   assign w_push = wr_en && (!w_full || w_pop);
   assign w_drop = wr_en && !w_push;

   // Match vector indexed by age: slot 0 is the oldest queued write.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_match
         logic [PW-1:0] w_idx;
         assign w_idx        = r_rd_ptr + PW'(gi);
         assign w_match[gi]  = (CW'(gi) < r_cnt) &&
                               (r_fifo_px[w_idx] == rd_px) &&
                               (r_fifo_py[w_idx] == rd_py);
         assign w_mdt[gi]    = r_fifo_dt[w_idx];
      end
   endgenerate

   // Later (newer) matches override; the accepted incoming write is newest of all.
   always_comb begin
      w_fwd_hit = 1'b0;
      w_fwd_dt  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (w_match[k]) begin
            w_fwd_hit = 1'b1;
            w_fwd_dt  = w_mdt[k];
         end
      end
      if (w_push && (wr_px == rd_px) && (wr_py == rd_py)) begin
         w_fwd_hit = 1'b1;
         w_fwd_dt  = wr_dt;
      end
      if (!rd_en) begin
         w_fwd_hit = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_px[r_wr_ptr] <= wr_px;
         r_fifo_py[r_wr_ptr] <= wr_py;
         r_fifo_dt[r_wr_ptr] <= wr_dt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_cnt     <= '0;
         r_ovf     <= 1'b0;
         r_ram_en  <= 1'b0;
         r_ram_we  <= 1'b0;
         r_ram_px  <= '0;
         r_ram_py  <= '0;
         r_ram_wdt <= '0;
         r_hit1    <= 1'b0;
         r_hit2    <= 1'b0;
         r_fdt1    <= '0;
         r_fdt2    <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);

         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (clr) begin
            r_ovf <= 1'b0;
         end

         if (rd_en) begin
            r_ram_en <= 1'b1;
            r_ram_we <= 1'b0;
            r_ram_px <= rd_px;
            r_ram_py <= rd_py;
         end else if (w_pop) begin
            r_ram_en  <= 1'b1;
            r_ram_we  <= 1'b1;
            r_ram_px  <= r_fifo_px[r_rd_ptr];
            r_ram_py  <= r_fifo_py[r_rd_ptr];
            r_ram_wdt <= r_fifo_dt[r_rd_ptr];
         end else begin
            r_ram_en <= 1'b0;
         end

         // Forwarding result travels alongside the RAM read latency.
         r_hit1 <= w_fwd_hit;
         r_fdt1 <= w_fwd_dt;
         r_hit2 <= r_hit1;
         r_fdt2 <= r_fdt1;
      end
   end

   assign ram_en   = r_ram_en;
   assign ram_we   = r_ram_we;
   assign ram_px   = r_ram_px;
   assign ram_py   = r_ram_py;
   assign ram_wdt  = r_ram_wdt;
   assign fifo_cnt = r_cnt;
   assign empty    = (r_cnt == '0);
   assign ovf      = r_ovf;
   assign rd_vl    = ram_rd_vl;
   assign rd_dt    = ram_rd_vl ? (r_hit2 ? r_fdt2 : ram_rd_dt) : '0;

endmodule
